// File: rtl/fir_pkg.sv
// Shared definitions for the FIR MAC sequencer.
// Holds the data/coefficient/accumulator widths, the sequencer state encoding,
// the rounding constants, the saturation limits and the round/saturate helper.
package fir_pkg;

    localparam int unsigned DATA_W    = 20;
    localparam int unsigned COEF_W    = 16;
    localparam int unsigned ADD_W     = 3;
    localparam int unsigned TAPS      = 8;
    localparam int unsigned ACC_W     = DATA_W + COEF_W + ADD_W;
    localparam int unsigned PROD_W    = DATA_W + COEF_W;
    localparam int unsigned RND_SHIFT = 15;

    // Half an LSB of the Q1.15 result, added before the arithmetic shift
    localparam logic signed [ACC_W-1:0] RND_CONST = ACC_W'(1 << (RND_SHIFT - 1));

    // Output range of a signed DATA_W sample, held at accumulator width
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fir_state_t;

    // Round half up, drop the Q15 fraction, clamp into the DATA_W range
    function automatic logic [DATA_W-1:0] round_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] r;
        r = (acc + RND_CONST) >>> RND_SHIFT;
        if (r > SAT_MAX) begin
            return DATA_W'(SAT_MAX);
        end else if (r < SAT_MIN) begin
            return DATA_W'(SAT_MIN);
        end else begin
            return DATA_W'(r);
        end
    endfunction

endpackage

// File: rtl/fir_coef_rom.sv
// Combinational coefficient ROM for the FIR MAC sequencer.
// Ports:
//   Add  - tap address
//   coef - signed Q1.15 coefficient for that tap
// COEF_SET selects the table: 0 = symmetric lowpass, 1 = full scale on every tap.
module fir_coef_rom
    import fir_pkg::*;
#(
    parameter int unsigned COEF_SET = 0
)
(
    input  logic [ADD_W-1:0]  Add,
    output logic [COEF_W-1:0] coef
);

    always_comb begin
        coef = '0;
        if (COEF_SET == 1) begin
            coef = COEF_W'(32767);
        end else begin
            case (Add)
                ADD_W'(0): coef = COEF_W'(1024);
                ADD_W'(1): coef = COEF_W'(2048);
                ADD_W'(2): coef = COEF_W'(4096);
                ADD_W'(3): coef = COEF_W'(8192);
                ADD_W'(4): coef = COEF_W'(8192);
                ADD_W'(5): coef = COEF_W'(4096);
                ADD_W'(6): coef = COEF_W'(2048);
                ADD_W'(7): coef = COEF_W'(1024);
                default:   coef = '0;
            endcase
        end
    end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Reader side of the FIR delay line: on each start strobe walks the tap
// address, multiplies each tap by its coefficient, accumulates, then rounds
// and saturates into one filtered sample.
// Ports:
//   clk     - system clock, rising edge
//   reset   - synchronous active-high reset
//   start   - new sample has entered the delay line
//   D       - tap data addressed by Add (combinational from the delay line)
//   Add     - tap address to the delay line
//   Y       - filtered sample, held between results
//   y_valid - one-cycle pulse when Y updates
//   busy    - convolution in progress
//   overrun - one-cycle pulse when start arrives while busy
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int unsigned COEF_SET = 0
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] D,
    output logic [ADD_W-1:0]  Add,
    output logic [DATA_W-1:0] Y,
    output logic              y_valid,
    output logic              busy,
    output logic              overrun
);

    fir_state_t               state;
    logic [COEF_W-1:0]        coef;
    logic signed [PROD_W-1:0] prod_r;
    logic signed [ACC_W-1:0]  acc;
    logic                     pv;

    fir_coef_rom #(
        .COEF_SET (COEF_SET)
    ) u_coef_rom (
        .Add  (Add),
        .coef (coef)
    );

    assign busy = (state != IDLE);

    // Sequencer: Add doubles as the tap counter; the product is pipelined one
    // stage, so the accumulate lags the multiply by a cycle and DRAIN adds the last one.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            Add     <= '0;
            acc     <= '0;
            prod_r  <= '0;
            pv      <= 1'b0;
            Y       <= '0;
            y_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            y_valid <= 1'b0;
            overrun <= 1'b0;
            if (start && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    Add <= '0;
                    if (start) begin
                        acc   <= '0;
                        pv    <= 1'b0;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    prod_r <= PROD_W'($signed(D)) * PROD_W'($signed(coef));
                    pv     <= 1'b1;
                    if (pv) begin
                        acc <= acc + ACC_W'(prod_r);
                    end
                    Add <= Add + ADD_W'(1);
                    if (Add == ADD_W'(TAPS - 1)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    acc   <= acc + ACC_W'(prod_r);
                    pv    <= 1'b0;
                    state <= DONE;
                end
                DONE: begin
                    Y       <= round_sat(acc);
                    y_valid <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer: one lowpass instance and one
// full-scale-coefficient instance, each fed by a modelled delay line.
module tb_fir_mac_sequencer;

    logic        clk;
    logic        reset;

    logic        start0, start1;
    logic [19:0] D0, D1;
    logic [2:0]  Add0, Add1;
    logic [19:0] Y0, Y1;
    logic        y_valid0, y_valid1;
    logic        busy0, busy1;
    logic        overrun0, overrun1;

    logic [19:0] taps0 [8];
    logic [19:0] taps1 [8];

    logic [19:0] q0 [$];
    logic [19:0] q1 [$];
    logic [19:0] exp0, exp1;

    int n_checks;
    int n_pass;

    assign D0 = taps0[Add0];
    assign D1 = taps1[Add1];

    fir_mac_sequencer #(.COEF_SET(0)) dut0 (
        .clk (clk), .reset (reset), .start (start0), .D (D0), .Add (Add0),
        .Y (Y0), .y_valid (y_valid0), .busy (busy0), .overrun (overrun0)
    );

    fir_mac_sequencer #(.COEF_SET(1)) dut1 (
        .clk (clk), .reset (reset), .start (start1), .D (D1), .Add (Add1),
        .Y (Y1), .y_valid (y_valid1), .busy (busy1), .overrun (overrun1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill0(input logic [19:0] v);
        for (int i = 0; i < 8; i++) taps0[i] = v;
    endtask

    task automatic fill1(input logic [19:0] v);
        for (int i = 0; i < 8; i++) taps1[i] = v;
    endtask

    // Scoreboard pop for the lowpass instance
    always @(negedge clk) begin
        if (y_valid0 === 1'b1) begin
            n_checks++;
            if (q0.size() == 0) begin
                $display("FAIL y0_unexpected: y_valid with Y=%h, no result pending", Y0);
            end else begin
                exp0 = q0.pop_front();
                if (Y0 !== exp0) $display("FAIL y0_value: got %h want %h", Y0, exp0);
                else n_pass++;
            end
        end
    end

    // Scoreboard pop for the full-scale instance
    always @(negedge clk) begin
        if (y_valid1 === 1'b1) begin
            n_checks++;
            if (q1.size() == 0) begin
                $display("FAIL y1_unexpected: y_valid with Y=%h, no result pending", Y1);
            end else begin
                exp1 = q1.pop_front();
                if (Y1 !== exp1) $display("FAIL y1_value: got %h want %h", Y1, exp1);
                else n_pass++;
            end
        end
    end

    task automatic test_reset();
        n_checks++; if (Y0 !== 20'h0) $display("FAIL reset_y: got %h want 0", Y0); else n_pass++;
        n_checks++; if (y_valid0 !== 1'b0) $display("FAIL reset_valid: got %b want 0", y_valid0); else n_pass++;
        n_checks++; if (busy0 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy0); else n_pass++;
        n_checks++; if (Add0 !== 3'd0) $display("FAIL reset_add: got %0d want 0", Add0); else n_pass++;
        n_checks++; if (overrun0 !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun0); else n_pass++;
        n_checks++; if (busy1 !== 1'b0) $display("FAIL reset_busy1: got %b want 0", busy1); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int nv;
        int lat;
        fill0(20'd1000);
        start0 = 1'b1; tick(); start0 = 1'b0;
        tick(); tick(); tick();
        n_checks++; if (busy0 !== 1'b1) $display("FAIL mid_busy: got %b want 1", busy0); else n_pass++;
        n_checks++; if (Add0 !== 3'd3) $display("FAIL mid_add: got %0d want 3", Add0); else n_pass++;
        reset = 1'b1; tick(); reset = 1'b0;
        n_checks++; if (busy0 !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy0); else n_pass++;
        n_checks++; if (Add0 !== 3'd0) $display("FAIL abort_add: got %0d want 0", Add0); else n_pass++;
        nv = 0;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (y_valid0 === 1'b1) nv++;
        end
        n_checks++; if (nv !== 0) $display("FAIL abort_no_valid: got %0d pulses want 0", nv); else n_pass++;
        n_checks++; if (Y0 !== 20'h0) $display("FAIL abort_y: got %h want 0", Y0); else n_pass++;
        q0.push_back(20'd938);
        start0 = 1'b1; tick(); start0 = 1'b0;
        lat = -1;
        for (int c = 1; c <= 16 && lat < 0; c++) begin
            tick();
            if (y_valid0 === 1'b1) lat = c;
        end
        n_checks++; if (lat !== 10) $display("FAIL after_abort_latency: got %0d want 10", lat); else n_pass++;
        tick();
    endtask

    task automatic test_lowpass_dc();
        logic exp_busy;
        logic exp_valid;
        fill0(20'd1000);
        q0.push_back(20'd938);
        start0 = 1'b1; tick(); start0 = 1'b0;
        for (int c = 0; c <= 11; c++) begin
            if (c > 0) tick();
            exp_busy  = (c <= 9);
            exp_valid = (c == 10);
            if (c <= 7) begin
                n_checks++;
                if (Add0 !== 3'(c)) $display("FAIL dc_add_e%0d: got %0d want %0d", c, Add0, c); else n_pass++;
            end
            n_checks++;
            if (busy0 !== exp_busy) $display("FAIL dc_busy_e%0d: got %b want %b", c, busy0, exp_busy); else n_pass++;
            n_checks++;
            if (y_valid0 !== exp_valid) $display("FAIL dc_valid_e%0d: got %b want %b", c, y_valid0, exp_valid); else n_pass++;
        end
        tick(); tick();
        n_checks++; if (Y0 !== 20'd938) $display("FAIL dc_hold: got %h want %h", Y0, 20'd938); else n_pass++;
    endtask

    task automatic test_impulse_and_negative();
        int lat;
        fill0(20'h0);
        taps0[3] = 20'h7FFFF;
        q0.push_back(20'h20000);
        start0 = 1'b1; tick(); start0 = 1'b0;
        lat = -1;
        for (int c = 1; c <= 16 && lat < 0; c++) begin
            tick();
            if (y_valid0 === 1'b1) lat = c;
        end
        n_checks++; if (lat !== 10) $display("FAIL impulse_latency: got %0d want 10", lat); else n_pass++;
        tick();
        fill0(20'h80000);
        q0.push_back(20'h88000);
        start0 = 1'b1; tick(); start0 = 1'b0;
        lat = -1;
        for (int c = 1; c <= 16 && lat < 0; c++) begin
            tick();
            if (y_valid0 === 1'b1) lat = c;
        end
        n_checks++; if (lat !== 10) $display("FAIL negative_latency: got %0d want 10", lat); else n_pass++;
        tick();
    endtask

    task automatic test_saturation();
        int lat;
        fill1(20'h7FFFF);
        q1.push_back(20'h7FFFF);
        start1 = 1'b1; tick(); start1 = 1'b0;
        lat = -1;
        for (int c = 1; c <= 16 && lat < 0; c++) begin
            tick();
            if (y_valid1 === 1'b1) lat = c;
        end
        n_checks++; if (lat !== 10) $display("FAIL sat_pos_latency: got %0d want 10", lat); else n_pass++;
        tick();
        fill1(20'h80000);
        q1.push_back(20'h80000);
        start1 = 1'b1; tick(); start1 = 1'b0;
        lat = -1;
        for (int c = 1; c <= 16 && lat < 0; c++) begin
            tick();
            if (y_valid1 === 1'b1) lat = c;
        end
        n_checks++; if (lat !== 10) $display("FAIL sat_neg_latency: got %0d want 10", lat); else n_pass++;
        tick();
    endtask

    task automatic test_overrun();
        int nv;
        fill0(20'd1000);
        q0.push_back(20'd938);
        start0 = 1'b1; tick(); start0 = 1'b0;
        nv = 0;
        for (int c = 1; c <= 24; c++) begin
            tick();
            if (y_valid0 === 1'b1) nv++;
            if (c == 4) start0 = 1'b1;
            if (c == 5) begin
                start0 = 1'b0;
                n_checks++;
                if (overrun0 !== 1'b1) $display("FAIL overrun_pulse: got %b want 1", overrun0); else n_pass++;
                n_checks++;
                if (Add0 !== 3'd5) $display("FAIL overrun_add: got %0d want 5", Add0); else n_pass++;
            end
            if (c == 6) begin
                n_checks++;
                if (overrun0 !== 1'b0) $display("FAIL overrun_width: got %b want 0", overrun0); else n_pass++;
            end
            if (c == 10) begin
                n_checks++;
                if (y_valid0 !== 1'b1) $display("FAIL overrun_valid_e10: got %b want 1", y_valid0); else n_pass++;
            end
        end
        n_checks++; if (nv !== 1) $display("FAIL overrun_results: got %0d pulses want 1", nv); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat;
        fill0(20'd1000);
        q0.push_back(20'd938);
        start0 = 1'b1; tick(); start0 = 1'b0;
        lat = -1;
        for (int c = 1; c <= 16 && lat < 0; c++) begin
            tick();
            if (y_valid0 === 1'b1) lat = c;
        end
        n_checks++; if (lat !== 10) $display("FAIL b2b_first_latency: got %0d want 10", lat); else n_pass++;
        // Next sample strobe lands in the y_valid cycle
        fill0(20'h80000);
        q0.push_back(20'h88000);
        start0 = 1'b1; tick(); start0 = 1'b0;
        n_checks++; if (busy0 !== 1'b1) $display("FAIL b2b_accepted: got busy %b want 1", busy0); else n_pass++;
        n_checks++; if (overrun0 !== 1'b0) $display("FAIL b2b_overrun: got %b want 0", overrun0); else n_pass++;
        lat = -1;
        for (int c = 1; c <= 16 && lat < 0; c++) begin
            tick();
            if (y_valid0 === 1'b1) lat = c;
        end
        n_checks++; if (lat !== 10) $display("FAIL b2b_second_latency: got %0d want 10", lat); else n_pass++;
        tick(); tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        start0   = 1'b0;
        start1   = 1'b0;
        fill0(20'h0);
        fill1(20'h0);
        tick(); tick();
        test_reset();
        reset = 1'b0;
        tick();
        test_reset_mid();
        test_lowpass_dc();
        test_impulse_and_negative();
        test_saturation();
        test_overrun();
        test_back_to_back();
        tick(); tick();
        n_checks++; if (q0.size() !== 0) $display("FAIL q0_drained: got %0d pending want 0", q0.size()); else n_pass++;
        n_checks++; if (q1.size() !== 0) $display("FAIL q1_drained: got %0d pending want 0", q1.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
